// File: rtl/shift_arbiter_ctrl.sv
// Two-requester arbiter sharing one external logical-right shifter; left shifts
// are done by bit-reversing operand and result. Define SHIFT_ARB_FIXED_PRIO_EN for fixed priority to requester 0.
module shift_arbiter_ctrl #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [4:0]        req0_amt,
  input  logic              req0_left,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [4:0]        req1_amt,
  input  logic              req1_left,
  output logic [DATA_W-1:0] sh_a,
  output logic [DATA_W-1:0] sh_b,
  input  logic [DATA_W-1:0] sh_out,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [DATA_W-1:0] r_data;
  logic [4:0]        r_amt;
  logic              r_left;
  logic              r_id;
  logic [DATA_W-1:0] r_rsp_data;
  logic              w_grant;
  logic              w_idle;
  logic              w_accept;

  function automatic logic [DATA_W-1:0] bit_rev(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = v[DATA_W-1-i];
    end
    return r;
  endfunction

  // w_grant is the index of the requester that would win this cycle.
`ifdef SHIFT_ARB_FIXED_PRIO_EN
  assign w_grant = ~req0_valid;
`else
  logic r_last_grant;

  assign w_grant = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

  // Pointer resets to 1 so requester 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_last_grant <= w_grant;
    end
  end
`endif

  // Readies are gated by rst_n so they drop the instant reset asserts.
  assign w_idle     = (r_state == IDLE) && rst_n;
  assign req0_ready = w_idle && req0_valid && !w_grant;
  assign req1_ready = w_idle && req1_valid &&  w_grant;
  assign w_accept   = req0_ready || req1_ready;

  assign rsp_id   = r_id;
  assign rsp_data = r_rsp_data;

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next_state = r_state;
    sh_a         = '0;
    sh_b         = '0;
    rsp_valid    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_accept) w_next_state = ISSUE;
      end
      ISSUE: begin
        sh_a         = r_left ? bit_rev(r_data) : r_data;
        sh_b         = {{(DATA_W-5){1'b0}}, r_amt};
        w_next_state = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Operand and result registers are cleared on reset so outputs read 0 afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data     <= '0;
      r_amt      <= '0;
      r_left     <= 1'b0;
      r_id       <= 1'b0;
      r_rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_data <= w_grant ? req1_data : req0_data;
        r_amt  <= w_grant ? req1_amt  : req0_amt;
        r_left <= w_grant ? req1_left : req0_left;
        r_id   <= w_grant;
      end
      if (r_state == ISSUE) begin
        r_rsp_data <= r_left ? bit_rev(sh_out) : sh_out;
      end
    end
  end

endmodule

// File: tb/tb_shift_arbiter_ctrl.sv
// Directed bench for shift_arbiter_ctrl; the bench itself plays the external
// logical-right shifter. Honours SHIFT_ARB_FIXED_PRIO_EN for contention expectations.
module tb_shift_arbiter_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_left;
  logic [31:0] req0_data;
  logic [4:0]  req0_amt;
  logic        req1_valid, req1_ready, req1_left;
  logic [31:0] req1_data;
  logic [4:0]  req1_amt;
  logic [31:0] sh_a, sh_b, sh_out;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign sh_out = sh_a >> sh_b[4:0];

  shift_arbiter_ctrl #(.DATA_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_amt   (req0_amt),
    .req0_left  (req0_left),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_amt   (req1_amt),
    .req1_left  (req1_left),
    .sh_a       (sh_a),
    .sh_b       (sh_b),
    .sh_out     (sh_out),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit id, input bit v, input logic [31:0] d,
                           input logic [4:0] a, input bit l);
    if (id == 1'b0) begin
      req0_valid = v; req0_data = d; req0_amt = a; req0_left = l;
    end else begin
      req1_valid = v; req1_data = d; req1_amt = a; req1_left = l;
    end
  endtask

  // Single uncontended transaction with rsp_ready held high.
  task automatic run_txn(input string tag, input bit id, input logic [31:0] d,
                         input logic [4:0] a, input bit l,
                         input logic [31:0] exp_sha, input logic [31:0] exp_rsp);
    drive_req(id, 1'b1, d, a, l);
    #1;
    check({tag, ".ready"}, {31'b0, id ? req1_ready : req0_ready}, 32'd1);
    tick();
    drive_req(id, 1'b0, 32'h0, 5'd0, 1'b0);
    check({tag, ".sh_a"}, sh_a, exp_sha);
    check({tag, ".sh_b"}, sh_b, {27'b0, a});
    tick();
    check({tag, ".rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, ".rsp_data"}, rsp_data, exp_rsp);
    check({tag, ".rsp_id"}, {31'b0, rsp_id}, {31'b0, id});
    tick();
    check({tag, ".back_idle"}, {31'b0, rsp_valid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit exp_g;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    drive_req(1'b0, 1'b1, 32'hFFFF_FFFF, 5'd3, 1'b0);
    drive_req(1'b1, 1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    tick();
    check("rst.req0_ready", {31'b0, req0_ready}, 32'd0);
    check("rst.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst.sh_a", sh_a, 32'h0);
    check("rst.sh_b", sh_b, 32'h0);
    check("rst.rsp_data", rsp_data, 32'h0);
    drive_req(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
    rst_n = 1'b1;

    run_txn("r0_right4", 1'b0, 32'h8000_0000, 5'd4, 1'b0, 32'h8000_0000, 32'h0800_0000);
    run_txn("r1_left31", 1'b1, 32'h0000_0001, 5'd31, 1'b1, 32'h8000_0000, 32'h8000_0000);
    run_txn("amt0_left", 1'b0, 32'hDEAD_BEEF, 5'd0, 1'b1, 32'hF77D_B57B, 32'hDEAD_BEEF);
    run_txn("amt31_right", 1'b1, 32'hFFFF_FFFF, 5'd31, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001);

    // Continuous contention: last grant was requester 1.
    drive_req(1'b0, 1'b1, 32'h0000_00F0, 5'd4, 1'b0);
    drive_req(1'b1, 1'b1, 32'h0000_0F00, 5'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
`ifdef SHIFT_ARB_FIXED_PRIO_EN
      exp_g = 1'b0;
`else
      exp_g = i[0];
`endif
      #1;
      check($sformatf("rr%0d.req0_ready", i), {31'b0, req0_ready}, {31'b0, ~exp_g});
      check($sformatf("rr%0d.req1_ready", i), {31'b0, req1_ready}, {31'b0, exp_g});
      tick();
      tick();
      check($sformatf("rr%0d.rsp_id", i), {31'b0, rsp_id}, {31'b0, exp_g});
      check($sformatf("rr%0d.rsp_data", i), rsp_data, exp_g ? 32'h0000_F000 : 32'h0000_000F);
      tick();
    end
    drive_req(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
    drive_req(1'b1, 1'b0, 32'h0, 5'd0, 1'b0);

    // Backpressure: response held for 5 cycles while requester 1 waits.
    rsp_ready = 1'b0;
    drive_req(1'b0, 1'b1, 32'h1234_5678, 5'd8, 1'b0);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
    tick();
    drive_req(1'b1, 1'b1, 32'hA5A5_A5A5, 5'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp%0d.rsp_valid", i), {31'b0, rsp_valid}, 32'd1);
      check($sformatf("bp%0d.rsp_data", i), rsp_data, 32'h0012_3456);
      check($sformatf("bp%0d.rsp_id", i), {31'b0, rsp_id}, 32'd0);
      check($sformatf("bp%0d.readies", i), {30'b0, req1_ready, req0_ready}, 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    check("bp.idle_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("bp.idle_sh_a", sh_a, 32'h0);
    check("bp.idle_req1_ready", {31'b0, req1_ready}, 32'd1);
    tick();
    drive_req(1'b1, 1'b0, 32'h0, 5'd0, 1'b0);
    check("bp.issue_sh_a", sh_a, 32'hA5A5_A5A5);
    check("bp.issue_sh_b", sh_b, 32'd1);
    tick();
    check("bp.rsp_data", rsp_data, 32'h4B4B_4B4A);
    check("bp.rsp_id", {31'b0, rsp_id}, 32'd1);
    tick();

    // Reset during ISSUE after requester 0 was granted.
    drive_req(1'b0, 1'b1, 32'h0000_FFFF, 5'd0, 1'b0);
    tick();
    check("rstiss.pre_sh_a", sh_a, 32'h0000_FFFF);
    drive_req(1'b1, 1'b1, 32'h0000_0001, 5'd0, 1'b0);
    rst_n = 1'b0;
    #1;
    check("rstiss.sh_a", sh_a, 32'h0);
    check("rstiss.sh_b", sh_b, 32'h0);
    check("rstiss.rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rstiss.rsp_data", rsp_data, 32'h0);
    check("rstiss.rsp_id", {31'b0, rsp_id}, 32'd0);
    check("rstiss.readies", {30'b0, req1_ready, req0_ready}, 32'd0);
    tick();
    tick();
    check("rstiss.no_rsp", {31'b0, rsp_valid}, 32'd0);
    rst_n = 1'b1;
    #1;
    check("rstiss.req0_ready", {31'b0, req0_ready}, 32'd1);
    check("rstiss.req1_ready", {31'b0, req1_ready}, 32'd0);
    tick();
    drive_req(1'b0, 1'b0, 32'h0, 5'd0, 1'b0);
    drive_req(1'b1, 1'b0, 32'h0, 5'd0, 1'b0);
    check("rstiss.issue_sh_a", sh_a, 32'h0000_FFFF);
    tick();
    check("rstiss.rsp_id", {31'b0, rsp_id}, 32'd0);
    check("rstiss.rsp_data2", rsp_data, 32'h0000_FFFF);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
